fifo_single_clock_reg_v3: RTL and testbench

FIFO_SINGLE_CLOCK_REG_V3 -- requirements
Module: fifo_single_clock_reg_v3

---
 rtl/fifo_single_clock_reg_v3.sv | 97 +++++++++
 tb/tb_fifo_single_clock_reg_v3.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_single_clock_reg_v3.sv
// Single-clock register-array FIFO with first-word fall-through or registered read data.
// Define FIFO_SINGLE_CLOCK_REG_V3_STATS_EN to add saturating overflow/underflow counters.
module fifo_single_clock_reg_v3 #(
    parameter FWFT_MODE      = "TRUE",
    parameter int DEPTH      = 8,
    parameter int DATA_W     = 32,
    parameter int AFULL_LVL  = DEPTH - 1,
    parameter int AEMPTY_LVL = 1,
    localparam int DEPTH_W   = $clog2(DEPTH + 1),
    localparam int PTR_W     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              w_req,
    input  logic [DATA_W-1:0] w_data,
    input  logic              r_req,
    output logic [DATA_W-1:0] r_data,
    output logic [DEPTH_W-1:0] cnt,
    output logic              empty,
    output logic              full,
    output logic              aempty,
    output logic              afull,
    output logic              fail
`ifdef FIFO_SINGLE_CLOCK_REG_V3_STATS_EN
    ,
    output logic [15:0]       ovf_cnt,
    output logic [15:0]       udf_cnt
`endif
);

    logic [DATA_W-1:0] mem [0:DEPTH-1];
    logic [PTR_W-1:0]  w_ptr;
    logic [PTR_W-1:0]  r_ptr;
    logic              wr_en;
    logic              rd_en;

    assign empty  = (cnt == DEPTH_W'(0));
    assign full   = (cnt == DEPTH_W'(DEPTH));
    assign aempty = (cnt <= DEPTH_W'(AEMPTY_LVL));
    assign afull  = (cnt >= DEPTH_W'(AFULL_LVL));

    // A write into a full FIFO is still accepted when a read frees a slot in the same cycle.
    assign wr_en = w_req & (~full | r_req);
    assign rd_en = r_req & ~empty;
    assign fail  = (r_req & empty) | (w_req & full & ~r_req);

    always_ff @(posedge clk) begin
        if (nrst && wr_en)
            mem[w_ptr] <= w_data;
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            w_ptr <= '0;
            r_ptr <= '0;
            cnt   <= '0;
        end else begin
            if (wr_en)
                w_ptr <= (w_ptr == PTR_W'(DEPTH - 1)) ? '0 : w_ptr + 1'b1;
            if (rd_en)
                r_ptr <= (r_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    generate
        if (FWFT_MODE == "TRUE") begin : g_fwft
            assign r_data = empty ? '0 : mem[r_ptr];
        end else begin : g_reg
            always_ff @(posedge clk) begin
                if (!nrst)
                    r_data <= '0;
                else if (rd_en)
                    r_data <= mem[r_ptr];
            end
        end
    endgenerate

`ifdef FIFO_SINGLE_CLOCK_REG_V3_STATS_EN
    always_ff @(posedge clk) begin
        if (!nrst) begin
            ovf_cnt <= '0;
            udf_cnt <= '0;
        end else begin
            if (w_req && full && !r_req && ovf_cnt != 16'hFFFF)
                ovf_cnt <= ovf_cnt + 16'd1;
            if (r_req && empty && udf_cnt != 16'hFFFF)
                udf_cnt <= udf_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_single_clock_reg_v3.sv
// Directed bench for fifo_single_clock_reg_v3 (DEPTH=5, DATA_W=8); a FWFT and a registered-read
// instance share the same stimulus.
module tb_fifo_single_clock_reg_v3;

    logic       clk;
    logic       nrst;
    logic       w_req;
    logic [7:0] w_data;
    logic       r_req;

    logic [7:0] f_r_data;
    logic [2:0] f_cnt;
    logic       f_empty, f_full, f_aempty, f_afull, f_fail;
    logic [7:0] g_r_data;
    logic [2:0] g_cnt;
    logic       g_empty, g_full, g_aempty, g_afull, g_fail;
`ifdef FIFO_SINGLE_CLOCK_REG_V3_STATS_EN
    logic [15:0] f_ovf, f_udf, g_ovf, g_udf;
`endif

    int checks   = 0;
    int failures = 0;

    fifo_single_clock_reg_v3 #(
        .FWFT_MODE("TRUE"), .DEPTH(5), .DATA_W(8), .AFULL_LVL(4), .AEMPTY_LVL(1)
    ) dut_fwft (
        .clk(clk), .nrst(nrst), .w_req(w_req), .w_data(w_data), .r_req(r_req),
        .r_data(f_r_data), .cnt(f_cnt), .empty(f_empty), .full(f_full),
        .aempty(f_aempty), .afull(f_afull), .fail(f_fail)
`ifdef FIFO_SINGLE_CLOCK_REG_V3_STATS_EN
        , .ovf_cnt(f_ovf), .udf_cnt(f_udf)
`endif
    );

    fifo_single_clock_reg_v3 #(
        .FWFT_MODE("FALSE"), .DEPTH(5), .DATA_W(8), .AFULL_LVL(4), .AEMPTY_LVL(1)
    ) dut_reg (
        .clk(clk), .nrst(nrst), .w_req(w_req), .w_data(w_data), .r_req(r_req),
        .r_data(g_r_data), .cnt(g_cnt), .empty(g_empty), .full(g_full),
        .aempty(g_aempty), .afull(g_afull), .fail(g_fail)
`ifdef FIFO_SINGLE_CLOCK_REG_V3_STATS_EN
        , .ovf_cnt(g_ovf), .udf_cnt(g_udf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic wr, input logic [7:0] wd, input logic rd);
        w_req  = wr;
        w_data = wd;
        r_req  = rd;
        #1;
    endtask

    task automatic advanceClock();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        nrst = 1'b0;
        applyStimulus(1'b0, 8'h00, 1'b0);
        advanceClock();
        advanceClock();
        nrst = 1'b1;
        #1;

        // Reset state
        checkOutput("rst_cnt", 32'(f_cnt), 32'd0);
        checkOutput("rst_empty", 32'(f_empty), 32'd1);
        checkOutput("rst_aempty", 32'(f_aempty), 32'd1);
        checkOutput("rst_full", 32'(f_full), 32'd0);
        checkOutput("rst_afull", 32'(f_afull), 32'd0);
        checkOutput("rst_fail", 32'(f_fail), 32'd0);
        checkOutput("rst_fwft_rdata", 32'(f_r_data), 32'd0);
        checkOutput("rst_reg_rdata", 32'(g_r_data), 32'd0);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("empty_read_fail", 32'(f_fail), 32'd1);
        applyStimulus(1'b0, 8'h00, 1'b0);

        // Fill 1..5, overflow with 6, drain in order
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(1'b1, 8'(i), 1'b0);
            advanceClock();
            checkOutput("fill_cnt", 32'(f_cnt), 32'(i));
            checkOutput("fill_afull", 32'(f_afull), (i >= 4) ? 32'd1 : 32'd0);
            checkOutput("fill_full", 32'(f_full), (i == 5) ? 32'd1 : 32'd0);
        end
        checkOutput("fill_head", 32'(f_r_data), 32'd1);
        applyStimulus(1'b1, 8'h06, 1'b0);
        checkOutput("ovf_fail", 32'(f_fail), 32'd1);
        advanceClock();
        checkOutput("ovf_cnt_kept", 32'(f_cnt), 32'd5);
`ifdef FIFO_SINGLE_CLOCK_REG_V3_STATS_EN
        checkOutput("ovf_stat", 32'(f_ovf), 32'd1);
`endif
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b1);
            checkOutput("drain_fwft", 32'(f_r_data), 32'(i));
            advanceClock();
            checkOutput("drain_reg", 32'(g_r_data), 32'(i));
        end
        checkOutput("drain_empty", 32'(f_empty), 32'd1);
        checkOutput("drain_cnt", 32'(f_cnt), 32'd0);

        // Interleaved traffic wrapping the pointers twice
        for (int k = 0; k < 12; k++) begin
            applyStimulus(1'b1, 8'(8'h20 + k), (k > 0));
            if (k > 0)
                checkOutput("wrap_head", 32'(f_r_data), 32'(8'h20 + k - 1));
            advanceClock();
            checkOutput("wrap_cnt", 32'(f_cnt), 32'd1);
        end
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("wrap_last", 32'(f_r_data), 32'h2B);
        advanceClock();
        checkOutput("wrap_reg_last", 32'(g_r_data), 32'h2B);
        checkOutput("wrap_empty", 32'(f_empty), 32'd1);

        // Simultaneous read/write while full
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 8'(8'h41 + i), 1'b0);
            advanceClock();
        end
        checkOutput("rw_full_pre", 32'(f_full), 32'd1);
        applyStimulus(1'b1, 8'hAA, 1'b1);
        checkOutput("rw_full_fail", 32'(f_fail), 32'd0);
        advanceClock();
        checkOutput("rw_full_cnt", 32'(f_cnt), 32'd5);
        checkOutput("rw_full_reg", 32'(g_r_data), 32'h41);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b1);
            checkOutput("rw_full_order", 32'(f_r_data), (i == 4) ? 32'hAA : 32'(8'h42 + i));
            advanceClock();
        end

        // Simultaneous read/write while empty: only the write happens
        applyStimulus(1'b1, 8'h3C, 1'b1);
        checkOutput("rw_empty_fail", 32'(f_fail), 32'd1);
        advanceClock();
        checkOutput("rw_empty_cnt", 32'(f_cnt), 32'd1);
        checkOutput("rw_empty_fwft", 32'(f_r_data), 32'h3C);
`ifdef FIFO_SINGLE_CLOCK_REG_V3_STATS_EN
        checkOutput("udf_stat", 32'(f_udf), 32'd1);
        checkOutput("ovf_stat_hold", 32'(f_ovf), 32'd1);
`endif
        checkOutput("rw_empty_reg_hold", 32'(g_r_data), 32'hAA);
        applyStimulus(1'b0, 8'h00, 1'b1);
        advanceClock();
        checkOutput("rw_empty_reg", 32'(g_r_data), 32'h3C);

        // Registered read: one cycle latency, held between reads
        applyStimulus(1'b1, 8'h11, 1'b0);
        advanceClock();
        checkOutput("reg_hold_pre", 32'(g_r_data), 32'h3C);
        applyStimulus(1'b0, 8'h00, 1'b1);
        advanceClock();
        checkOutput("reg_read", 32'(g_r_data), 32'h11);
        applyStimulus(1'b0, 8'h00, 1'b0);
        advanceClock();
        advanceClock();
        checkOutput("reg_hold_post", 32'(g_r_data), 32'h11);

        // Reset mid-operation discards contents
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 8'(8'h51 + i), 1'b0);
            advanceClock();
        end
        checkOutput("pre_rst_cnt", 32'(f_cnt), 32'd3);
        nrst = 1'b0;
        applyStimulus(1'b1, 8'h99, 1'b0);
        advanceClock();
        checkOutput("mid_rst_cnt", 32'(f_cnt), 32'd0);
        checkOutput("mid_rst_empty", 32'(f_empty), 32'd1);
        checkOutput("mid_rst_reg_rdata", 32'(g_r_data), 32'd0);
`ifdef FIFO_SINGLE_CLOCK_REG_V3_STATS_EN
        checkOutput("mid_rst_ovf", 32'(f_ovf), 32'd0);
        checkOutput("mid_rst_udf", 32'(f_udf), 32'd0);
`endif
        nrst = 1'b1;
        applyStimulus(1'b1, 8'h77, 1'b0);
        advanceClock();
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("post_rst_cnt", 32'(f_cnt), 32'd1);
        checkOutput("post_rst_fwft", 32'(f_r_data), 32'h77);
        applyStimulus(1'b0, 8'h00, 1'b1);
        advanceClock();
        checkOutput("post_rst_reg", 32'(g_r_data), 32'h77);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
